// File: rtl/core_boot_sequencer.sv
// -----------------------------------------------------------------------------
// core_boot_sequencer
//
// Bring-up sequencer for RISC_V_Core. A one-cycle boot request starts this
// sequence:
//   IDLE -> HOLD (core held in reset) -> START (one-cycle start pulse)
//        -> RUN (fixed cycle budget) -> REPORT (one-cycle report pulse)
//        -> DONE (one-cycle done pulse) -> IDLE
//
// Optional feature macro: CORE_BOOT_REPORT_EN
//   defined   : REPORT state exists and core_report pulses after RUN.
//   undefined : no REPORT state, core_report is tied low, and RUN goes
//               straight to DONE.
//
// Parameters
//   ADDRESS_BITS  width of boot_address / prog_address
//   RESET_CYCLES  cycles spent in HOLD (0 behaves as 1)
//   RUN_CYCLES    cycles spent in RUN  (0 behaves as 1)
//   CNT_BITS      width of the phase counter
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous reset, active low
//   boot_req      in   one-cycle boot request, honoured only in IDLE
//   boot_address  in   program entry address, latched when the request is accepted
//   abort         in   returns any active sequence to IDLE
//   core_reset    out  core reset, active high
//   core_start    out  core start pulse
//   prog_address  out  program address presented to the core
//   core_report   out  performance report pulse
//   busy          out  high in every state except IDLE
//   done          out  one-cycle completion pulse
//   cycle_count   out  RUN cycles in the last or current boot, saturating
// -----------------------------------------------------------------------------
module core_boot_sequencer #(
   parameter int ADDRESS_BITS = 20,
   parameter int RESET_CYCLES = 4,
   parameter int RUN_CYCLES   = 150,
   parameter int CNT_BITS     = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    boot_req,
   input  logic [ADDRESS_BITS-1:0] boot_address,
   input  logic                    abort,
   output logic                    core_reset,
   output logic                    core_start,
   output logic [ADDRESS_BITS-1:0] prog_address,
   output logic                    core_report,
   output logic                    busy,
   output logic                    done,
   output logic [31:0]             cycle_count
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HOLD   = 3'd1,
      ST_START  = 3'd2,
      ST_RUN    = 3'd3,
`ifdef CORE_BOOT_REPORT_EN
      ST_REPORT = 3'd4,
`endif
      ST_DONE   = 3'd5
   } state_t;

   // Zero-length phases are stretched to one cycle so that every state is
   // visited at least once.
   localparam int RESET_EFF = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
   localparam int RUN_EFF   = (RUN_CYCLES   < 1) ? 1 : RUN_CYCLES;

   // The phase counter counts down to zero; zero marks the last cycle of
   // the phase, so each phase loads (length - 1).
   localparam logic [CNT_BITS-1:0] HOLD_LOAD = CNT_BITS'(RESET_EFF - 1);
   localparam logic [CNT_BITS-1:0] RUN_LOAD  = CNT_BITS'(RUN_EFF - 1);

`ifdef CORE_BOOT_REPORT_EN
   localparam state_t RUN_EXIT = ST_REPORT;
`else
   localparam state_t RUN_EXIT = ST_DONE;
`endif

   state_t              state_r;
   state_t              next_state_s;
   logic [CNT_BITS-1:0] phase_cnt_r;
   logic                expired_s;
   logic                accept_s;

   // Next-state decision: abort wins, then phase expiry, then boot_req.
   always_comb begin
      next_state_s = state_r;
      expired_s    = (phase_cnt_r == {CNT_BITS{1'b0}});
      case (state_r)
         ST_IDLE: begin
            if (boot_req && !abort) begin
               next_state_s = ST_HOLD;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (abort) begin
               next_state_s = ST_IDLE;
            end else if (expired_s) begin
               next_state_s = ST_START;
            end else begin
               next_state_s = ST_HOLD;
            end
         end
         ST_START: begin
            if (abort) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               next_state_s = ST_IDLE;
            end else if (expired_s) begin
               next_state_s = RUN_EXIT;
            end else begin
               next_state_s = ST_RUN;
            end
         end
`ifdef CORE_BOOT_REPORT_EN
         ST_REPORT: begin
            if (abort) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   assign accept_s = (state_r == ST_IDLE) && (next_state_s == ST_HOLD);

   // State, phase counter, latched address, run counter and the outputs,
   // which are decoded from the next state so they line up with it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         phase_cnt_r  <= {CNT_BITS{1'b0}};
         prog_address <= {ADDRESS_BITS{1'b0}};
         cycle_count  <= 32'd0;
         core_reset   <= 1'b1;
         core_start   <= 1'b0;
         core_report  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_r <= next_state_s;

         if (accept_s) begin
            phase_cnt_r <= HOLD_LOAD;
         end else if ((state_r == ST_START) && (next_state_s == ST_RUN)) begin
            phase_cnt_r <= RUN_LOAD;
         end else if (phase_cnt_r != {CNT_BITS{1'b0}}) begin
            phase_cnt_r <= phase_cnt_r - {{(CNT_BITS-1){1'b0}}, 1'b1};
         end else begin
            phase_cnt_r <= phase_cnt_r;
         end

         if (accept_s) begin
            prog_address <= boot_address;
         end else begin
            prog_address <= prog_address;
         end

         // An aborted RUN cycle is not counted, so the count freezes at the
         // number of RUN cycles fully completed.
         if (accept_s) begin
            cycle_count <= 32'd0;
         end else if ((state_r == ST_RUN) && !abort &&
                      (cycle_count != 32'hFFFF_FFFF)) begin
            cycle_count <= cycle_count + 32'd1;
         end else begin
            cycle_count <= cycle_count;
         end

         core_reset  <= 1'b1;
         core_start  <= 1'b0;
         core_report <= 1'b0;
         busy        <= 1'b1;
         done        <= 1'b0;
         case (next_state_s)
            ST_IDLE: begin
               busy <= 1'b0;
            end
            ST_HOLD: begin
               core_reset <= 1'b1;
            end
            ST_START: begin
               core_reset <= 1'b0;
               core_start <= 1'b1;
            end
            ST_RUN: begin
               core_reset <= 1'b0;
            end
`ifdef CORE_BOOT_REPORT_EN
            ST_REPORT: begin
               core_reset  <= 1'b0;
               core_report <= 1'b1;
            end
`endif
            ST_DONE: begin
               done <= 1'b1;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_boot_sequencer
//
// Self-checking bench for core_boot_sequencer. Each accepted boot pushes the
// per-cycle expected outputs, derived from the documented cycle timeline,
// onto a scoreboard queue; a monitor on the falling edge pops and compares.
// A second instance with zero-length phases checks the minimum sequence.
// -----------------------------------------------------------------------------
module tb_core_boot_sequencer;

   localparam int AW     = 20;
   localparam int R_MAIN = 4;
   localparam int N_MAIN = 150;
`ifdef CORE_BOOT_REPORT_EN
   localparam int REP = 1;
`else
   localparam int REP = 0;
`endif

   typedef struct {
      int          cyc;
      logic        rst;
      logic        start;
      logic        report;
      logic        done;
      logic        busy;
      logic [AW-1:0] addr;
      logic [31:0] count;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          boot_req;
   logic [AW-1:0] boot_address;
   logic          abort;
   logic          core_reset, core_start, core_report, busy, done;
   logic [AW-1:0] prog_address;
   logic [31:0]   cycle_count;

   logic          z_boot_req;
   logic [AW-1:0] z_boot_address;
   logic          z_core_reset, z_core_start, z_core_report, z_busy, z_done;
   logic [AW-1:0] z_prog_address;
   logic [31:0]   z_cycle_count;

   int            cyc;
   int            tests_run;
   int            tests_failed;
   bit            mon_en;
   exp_t          sb_q[$];
   logic [AW-1:0] last_addr;
   logic [31:0]   last_count;

   core_boot_sequencer #(
      .ADDRESS_BITS(AW), .RESET_CYCLES(R_MAIN), .RUN_CYCLES(N_MAIN), .CNT_BITS(16)
   ) dut (
      .clock(clk), .reset(rst_n), .boot_req(boot_req), .boot_address(boot_address),
      .abort(abort), .core_reset(core_reset), .core_start(core_start),
      .prog_address(prog_address), .core_report(core_report), .busy(busy),
      .done(done), .cycle_count(cycle_count)
   );

   core_boot_sequencer #(
      .ADDRESS_BITS(AW), .RESET_CYCLES(0), .RUN_CYCLES(0), .CNT_BITS(16)
   ) dut_zero (
      .clock(clk), .reset(rst_n), .boot_req(z_boot_req), .boot_address(z_boot_address),
      .abort(1'b0), .core_reset(z_core_reset), .core_start(z_core_start),
      .prog_address(z_prog_address), .core_report(z_core_report), .busy(z_busy),
      .done(z_done), .cycle_count(z_cycle_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // Move to posedge+1 of cycle c.
   task automatic wait_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected outputs k cycles after a boot_req sampled at the end of cycle t.
   function automatic exp_t exp_at(input int t, input int k, input int r, input int n,
                                   input logic [AW-1:0] a);
      exp_t e;
      e.cyc = t + k; e.addr = a; e.rst = 1'b0; e.start = 1'b0; e.report = 1'b0;
      e.done = 1'b0; e.busy = 1'b1; e.count = 32'd0;
      if (k <= r) begin
         e.rst = 1'b1;
      end else if (k == r + 1) begin
         e.start = 1'b1;
      end else if (k <= r + 1 + n) begin
         e.count = 32'(k - (r + 2));
      end else if (REP == 1 && k == r + n + 2) begin
         e.report = 1'b1; e.count = 32'(n);
      end else if (k == r + n + 2 + REP) begin
         e.done = 1'b1; e.rst = 1'b1; e.count = 32'(n);
      end else begin
         e.busy = 1'b0; e.rst = 1'b1; e.count = 32'(n);
      end
      return e;
   endfunction

   task automatic compare_outputs(input string pfx, input exp_t e,
                                  input logic o_rst, input logic o_start, input logic o_rep,
                                  input logic o_done, input logic o_busy,
                                  input logic [AW-1:0] o_addr, input logic [31:0] o_cnt);
      check_value({pfx, "core_reset"},   32'(o_rst),   32'(e.rst));
      check_value({pfx, "core_start"},   32'(o_start), 32'(e.start));
      check_value({pfx, "core_report"},  32'(o_rep),   32'(e.report));
      check_value({pfx, "done"},         32'(o_done),  32'(e.done));
      check_value({pfx, "busy"},         32'(o_busy),  32'(e.busy));
      check_value({pfx, "prog_address"}, 32'(o_addr),  32'(e.addr));
      check_value({pfx, "cycle_count"},  o_cnt,        e.count);
   endtask

   // Scoreboard monitor: scheduled cycles are popped, otherwise IDLE is expected.
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            void'(sb_q.pop_front());
         end
         if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            last_addr  = e.addr;
            last_count = e.count;
         end else begin
            e.cyc = cyc; e.rst = 1'b1; e.start = 1'b0; e.report = 1'b0; e.done = 1'b0;
            e.busy = 1'b0; e.addr = last_addr; e.count = last_count;
         end
         compare_outputs("sb_", e, core_reset, core_start, core_report, done, busy,
                         prog_address, cycle_count);
      end
   end

   task automatic do_boot(input logic [AW-1:0] a);
      int t;
      t = cyc;
      boot_req = 1'b1;
      boot_address = a;
      for (int k = 1; k <= R_MAIN + N_MAIN + 3 + REP; k++) begin
         sb_q.push_back(exp_at(t, k, R_MAIN, N_MAIN, a));
      end
      wait_cycle(t + 1);
      boot_req = 1'b0;
   endtask

   task automatic do_abort(input int t, input logic [AW-1:0] a);
      int   frozen;
      exp_t e;
      frozen = cyc - (t + R_MAIN + 2);
      if (frozen < 0) frozen = 0;
      if (frozen > N_MAIN) frozen = N_MAIN;
      abort = 1'b1;
      while (sb_q.size() > 0 && sb_q[$].cyc > cyc) begin
         void'(sb_q.pop_back());
      end
      e.cyc = cyc + 1; e.rst = 1'b1; e.start = 1'b0; e.report = 1'b0; e.done = 1'b0;
      e.busy = 1'b0; e.addr = a; e.count = 32'(frozen);
      sb_q.push_back(e);
      wait_cycle(e.cyc);
      abort = 1'b0;
   endtask

   // Minimum-length sequence on the zero-parameter instance.
   initial begin
      exp_t e;
      z_boot_req = 1'b0;
      z_boot_address = 20'h00000;
      wait_cycle(5);
      z_boot_req = 1'b1;
      z_boot_address = 20'h00ABC;
      for (int k = 1; k <= 1 + 1 + 3 + REP; k++) begin
         wait_cycle(5 + k);
         z_boot_req = 1'b0;
         #3;
         e = exp_at(5, k, 1, 1, 20'h00ABC);
         compare_outputs("zero_", e, z_core_reset, z_core_start, z_core_report, z_done,
                         z_busy, z_prog_address, z_cycle_count);
      end
   end

   initial begin
      tests_run = 0;
      tests_failed = 0;
      mon_en = 1'b0;
      last_addr = 20'h00000;
      last_count = 32'd0;
      rst_n = 1'b1;
      boot_req = 1'b0;
      boot_address = 20'h00000;
      abort = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check_value("rst_core_reset",   32'(core_reset),   32'd1);
      check_value("rst_busy",         32'(busy),         32'd0);
      check_value("rst_prog_address", 32'(prog_address), 32'd0);
      check_value("rst_cycle_count",  cycle_count,       32'd0);
      mon_en = 1'b1;
      wait_cycle(2);
      rst_n = 1'b1;

      // Full boot; a second request mid-run must be ignored.
      wait_cycle(10);
      do_boot(20'h00100);
      wait_cycle(50);
      boot_req = 1'b1;
      boot_address = 20'h00200;
      wait_cycle(51);
      boot_req = 1'b0;

      // abort together with boot_req in IDLE rejects the request.
      wait_cycle(180);
      boot_req = 1'b1;
      abort = 1'b1;
      boot_address = 20'h000FF;
      wait_cycle(181);
      boot_req = 1'b0;
      abort = 1'b0;

      // Abort in RUN, then a fresh boot is accepted.
      wait_cycle(190);
      do_boot(20'h00300);
      wait_cycle(240);
      do_abort(190, 20'h00300);
      wait_cycle(250);
      do_boot(20'h00400);

      // Asynchronous reset mid-sequence, then a clean restart.
      wait_cycle(420);
      do_boot(20'h00500);
      wait_cycle(430);
      #1 rst_n = 1'b0;
      #1;
      check_value("async_core_reset",   32'(core_reset),   32'd1);
      check_value("async_core_start",   32'(core_start),   32'd0);
      check_value("async_busy",         32'(busy),         32'd0);
      check_value("async_prog_address", 32'(prog_address), 32'd0);
      check_value("async_cycle_count",  cycle_count,       32'd0);
      sb_q.delete();
      last_addr = 20'h00000;
      last_count = 32'd0;
      wait_cycle(433);
      rst_n = 1'b1;
      wait_cycle(440);
      do_boot(20'h00600);

      wait_cycle(620);
      check_value("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
